// File: rtl/data_memory_port_arbiter.sv
// Byte-serial arbiter sharing one single-port data SRAM between the
// MEM-stage port and a debug/loader port, big-endian byte order.
module data_memory_port_arbiter #(
  parameter int RAM_SIZE     = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [1:0]                  cpu_size,
  input  logic                        cpu_sign_extend,
  input  logic [31:0]                 cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  output logic                        cpu_ack,
  output logic [31:0]                 cpu_rdata,
  output logic                        cpu_stall,
  input  logic                        dbg_req,
  input  logic                        dbg_we,
  input  logic [31:0]                 dbg_addr,
  input  logic [31:0]                 dbg_wdata,
  output logic                        dbg_ack,
  output logic [31:0]                 dbg_rdata,
  output logic                        busy,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [$clog2(RAM_SIZE)-1:0] mem_addr,
  output logic [7:0]                  mem_wdata,
  input  logic [7:0]                  mem_rdata
);

  localparam int AW = $clog2(RAM_SIZE);
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, FINISH, DONE} state_t;

  state_t          state, state_nxt;
  logic            own_dbg;
  logic            we_q;
  logic [1:0]      size_q;
  logic            sx_q;
  logic [AW-1:0]   base_q;
  logic [31:0]     wdata_q;
  logic [1:0]      off_q;
  logic [23:0]     acc;
  logic            rd_pend;
  logic [3:0]      starve_cnt;

  logic            grant_any;
  logic            grant_dbg;
  logic [1:0]      gsize;
  logic [1:0]      start_off;
  logic [31:0]     fin;
  logic [31:0]     load_val;
  logic            unused;

  assign unused = ^{cpu_addr[31:AW], dbg_addr[31:AW]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_any = cpu_req || dbg_req;
    grant_dbg = dbg_req && (!cpu_req || starve_cnt == LIM);
    gsize     = grant_dbg ? SZ_WORD : cpu_size;
    case (gsize)
      SZ_BYTE: start_off = 2'd3;
      SZ_HALF: start_off = 2'd2;
      default: start_off = 2'd0;
    endcase
    case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   if (off_q == 2'd3) state_nxt = FINISH;
      FINISH:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state == ISSUE);
    mem_we    = mem_en && we_q;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != IDLE);
    cpu_stall = cpu_req && !cpu_ack;
    if (mem_en) begin
      mem_addr = base_q + AW'(off_q);
      case (off_q)
        2'd0:    mem_wdata = wdata_q[31:24];
        2'd1:    mem_wdata = wdata_q[23:16];
        2'd2:    mem_wdata = wdata_q[15:8];
        default: mem_wdata = wdata_q[7:0];
      endcase
    end
  end

  // Final read byte arrives during FINISH; extend from the merged value.
  always_comb begin
    fin = {acc, mem_rdata};
    case (size_q)
      SZ_BYTE: load_val = {{24{sx_q & fin[7]}}, fin[7:0]};
      SZ_HALF: load_val = {{16{sx_q & fin[15]}}, fin[15:0]};
      default: load_val = fin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_dbg    <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= SZ_WORD;
      sx_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      off_q      <= '0;
      acc        <= '0;
      rd_pend    <= 1'b0;
      starve_cnt <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      rd_pend <= (state == ISSUE);
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      if (rd_pend) acc <= fin[23:0];
      if (state == IDLE && grant_any) begin
        own_dbg <= grant_dbg;
        we_q    <= grant_dbg ? dbg_we : cpu_we;
        size_q  <= gsize;
        sx_q    <= grant_dbg ? 1'b0 : cpu_sign_extend;
        base_q  <= grant_dbg ? dbg_addr[AW-1:0] : cpu_addr[AW-1:0];
        wdata_q <= grant_dbg ? dbg_wdata : cpu_wdata;
        off_q   <= start_off;
        if (grant_dbg)
          starve_cnt <= '0;
        else if (dbg_req && starve_cnt != LIM)
          starve_cnt <= starve_cnt + 4'd1;
      end
      if (state == ISSUE) off_q <= off_q + 2'd1;
      if (state == FINISH) begin
        if (own_dbg) begin
          dbg_ack   <= 1'b1;
          dbg_rdata <= we_q ? 32'd0 : load_val;
        end else begin
          cpu_ack   <= 1'b1;
          cpu_rdata <= we_q ? 32'd0 : load_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_port_arbiter.sv
// Directed bench for data_memory_port_arbiter with a behavioural
// byte SRAM (read data one cycle after the strobe).
module tb_data_memory_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_sign_extend;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        busy, mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  ram [0:1023];
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [7:0]  ld_data;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_memory_port_arbiter #(.RAM_SIZE(1024), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_sign_extend(cpu_sign_extend), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic cpu_txn(input logic we, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a,
                         input logic [31:0] wd, output int lat,
                         output logic [31:0] rd);
    cpu_we = we; cpu_size = sz; cpu_sign_extend = sx;
    cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    lat = -1; rd = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        lat = i; rd = cpu_rdata;
        break;
      end
      tick();
    end
    if (lat >= 0) tick();
    cpu_req = 1'b0;
  endtask

  task automatic dbg_txn(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, output int lat,
                         output logic [31:0] rd);
    dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
    lat = -1; rd = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dbg_ack) begin
        lat = i; rd = dbg_rdata;
        break;
      end
      tick();
    end
    if (lat >= 0) tick();
    dbg_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_run++;
    if ({cpu_ack, dbg_ack, busy, mem_en, mem_we, cpu_stall} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {cpu_ack, dbg_ack, busy, mem_en, mem_we, cpu_stall});
    end
    n_run++;
    if ({mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== 82'b0) begin
      n_fail++;
      $display("FAIL reset_data: got addr %h wd %h crd %h drd %h want 0",
               mem_addr, mem_wdata, cpu_rdata, dbg_rdata);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_word_store();
    logic [31:0] w = 32'hDEADBEEF;
    cpu_we = 1'b1; cpu_size = 2'd2; cpu_sign_extend = 1'b0;
    cpu_addr = 32'h10; cpu_wdata = w; cpu_req = 1'b1;
    @(negedge clk);
    n_run++;
    if ({cpu_stall, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL store_t0: stall/busy %b want 10", {cpu_stall, busy});
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      @(negedge clk);
      if (k <= 4) begin
        n_run++;
        if ({mem_en, mem_we, cpu_stall, cpu_ack} !== 4'b1110 ||
            mem_addr !== 10'(10'h10 + k - 1) ||
            mem_wdata !== w[(4-k)*8 +: 8]) begin
          n_fail++;
          $display("FAIL store_byte%0d: en/we/stall/ack %b addr %h wd %h want 1110 %h %h",
                   k, {mem_en, mem_we, cpu_stall, cpu_ack}, mem_addr,
                   mem_wdata, 10'(10'h10 + k - 1), w[(4-k)*8 +: 8]);
        end
      end else if (k == 5) begin
        n_run++;
        if ({mem_en, cpu_ack, cpu_stall, busy} !== 4'b0011) begin
          n_fail++;
          $display("FAIL store_finish: en/ack/stall/busy %b want 0011",
                   {mem_en, cpu_ack, cpu_stall, busy});
        end
      end else begin
        n_run++;
        if ({cpu_ack, dbg_ack, cpu_stall} !== 3'b100 || cpu_rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL store_ack: ack/dack/stall %b rdata %h want 100 0",
                   {cpu_ack, dbg_ack, cpu_stall}, cpu_rdata);
        end
      end
    end
    tick();
    cpu_req = 1'b0;
    n_run++;
    if ({ram[16], ram[17], ram[18], ram[19]} !== w) begin
      n_fail++;
      $display("FAIL store_ram: got %h want %h",
               {ram[16], ram[17], ram[18], ram[19]}, w);
    end
  endtask

  task automatic test_loads();
    int lat;
    logic [31:0] rd;
    poke(10'h23, 8'h80);
    cpu_txn(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, lat, rd);
    n_run++;
    if (lat !== 3 || rd !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL byte_sx: lat %0d rdata %h want 3 FFFFFF80", lat, rd);
    end
    cpu_txn(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, lat, rd);
    n_run++;
    if (lat !== 3 || rd !== 32'h00000080) begin
      n_fail++;
      $display("FAIL byte_zx: lat %0d rdata %h want 3 00000080", lat, rd);
    end
    poke(10'h22, 8'h80);
    poke(10'h23, 8'h01);
    cpu_txn(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, lat, rd);
    n_run++;
    if (lat !== 4 || rd !== 32'hFFFF8001) begin
      n_fail++;
      $display("FAIL half_sx: lat %0d rdata %h want 4 FFFF8001", lat, rd);
    end
    cpu_txn(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, lat, rd);
    n_run++;
    if (lat !== 4 || rd !== 32'h00008001) begin
      n_fail++;
      $display("FAIL half_zx: lat %0d rdata %h want 4 00008001", lat, rd);
    end
    cpu_txn(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, lat, rd);
    n_run++;
    if (lat !== 6 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_load: lat %0d rdata %h want 6 DEADBEEF", lat, rd);
    end
    cpu_txn(1'b0, 2'd3, 1'b1, 32'h10, 32'h0, lat, rd);
    n_run++;
    if (lat !== 6 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL size3_load: lat %0d rdata %h want 6 DEADBEEF", lat, rd);
    end
  endtask

  task automatic test_arbitration();
    logic [5:0]  is_dbg = '0;
    int          n = 0;
    int          cyc = 0;
    int          dseen = 0;
    int          cbad = 0;
    logic [31:0] drd = '0;
    cpu_we = 1'b0; cpu_size = 2'd2; cpu_sign_extend = 1'b0;
    cpu_addr = 32'h10; cpu_wdata = 32'h0;
    dbg_we = 1'b1; dbg_addr = 32'h100; dbg_wdata = 32'hCAFEF00D;
    cpu_req = 1'b1; dbg_req = 1'b1;
    while (n < 6 && cyc < 200) begin
      @(negedge clk);
      if (cpu_ack) begin
        is_dbg[n] = 1'b0;
        n++;
        if (cpu_rdata !== 32'hDEADBEEF) cbad++;
      end
      if (dbg_ack && n < 6) begin
        is_dbg[n] = 1'b1;
        n++;
        if (dseen == 0) dbg_we = 1'b0;
        else drd = dbg_rdata;
        dseen++;
      end
      tick();
      cyc++;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    n_run++;
    if (n !== 6 || is_dbg !== 6'b100100) begin
      n_fail++;
      $display("FAIL arb_order: acks %0d order %b want 6 100100", n, is_dbg);
    end
    n_run++;
    if (drd !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL arb_dbg_read: got %h want CAFEF00D", drd);
    end
    n_run++;
    if (cbad !== 0) begin
      n_fail++;
      $display("FAIL arb_cpu_read: %0d bad cpu words want 0", cbad);
    end
  endtask

  task automatic test_wrap();
    logic [9:0]  wa [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [7:0]  wb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int          lat;
    logic [31:0] rd;
    dbg_we = 1'b1; dbg_addr = 32'h3FE; dbg_wdata = 32'h11223344;
    dbg_req = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      if (k < 4) begin
        n_run++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== wa[k] ||
            mem_wdata !== wb[k]) begin
          n_fail++;
          $display("FAIL wrap_byte%0d: en/we %b addr %h wd %h want 11 %h %h",
                   k, {mem_en, mem_we}, mem_addr, mem_wdata, wa[k], wb[k]);
        end
      end else if (k == 5) begin
        n_run++;
        if ({dbg_ack, cpu_ack} !== 2'b10 || dbg_rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL wrap_ack: dack/cack %b rdata %h want 10 0",
                   {dbg_ack, cpu_ack}, dbg_rdata);
        end
      end
    end
    tick();
    dbg_req = 1'b0;
    dbg_txn(1'b0, 32'h3FE, 32'h0, lat, rd);
    n_run++;
    if (lat !== 6 || rd !== 32'h11223344) begin
      n_fail++;
      $display("FAIL wrap_read: lat %0d rdata %h want 6 11223344", lat, rd);
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [31:0] rd;
    int          acks = 0;
    for (int i = 0; i < 4; i++) poke(10'(10'h40 + i), 8'hAA);
    cpu_we = 1'b1; cpu_size = 2'd2; cpu_sign_extend = 1'b0;
    cpu_addr = 32'h40; cpu_wdata = 32'h01020304; cpu_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if ({cpu_ack, dbg_ack, busy, mem_en, mem_we} !== 5'b0 ||
        {mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== 82'b0) begin
      n_fail++;
      $display("FAIL rstmid_outs: flags %b addr %h wd %h crd %h drd %h want 0",
               {cpu_ack, dbg_ack, busy, mem_en, mem_we}, mem_addr,
               mem_wdata, cpu_rdata, dbg_rdata);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      if (cpu_ack || dbg_ack || busy) acks++;
    end
    n_run++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: %0d active cycles want 0", acks);
    end
    n_run++;
    if ({ram[64], ram[65], ram[66], ram[67]} !== 32'h0102AAAA) begin
      n_fail++;
      $display("FAIL rstmid_ram: got %h want 0102AAAA",
               {ram[64], ram[65], ram[66], ram[67]});
    end
    tick();
    cpu_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd);
    n_run++;
    if (lat !== 6 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rstmid_load: lat %0d rdata %h want 6 DEADBEEF", lat, rd);
    end
    cpu_txn(1'b1, 2'd2, 1'b0, 32'h40, 32'h01020304, lat, rd);
    n_run++;
    if (lat !== 6 || {ram[64], ram[65], ram[66], ram[67]} !== 32'h01020304) begin
      n_fail++;
      $display("FAIL rstmid_store: lat %0d ram %h want 6 01020304", lat,
               {ram[64], ram[65], ram[66], ram[67]});
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd2; cpu_sign_extend = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    test_word_store();
    test_loads();
    test_arbitration();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
